// File: rtl/axis_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : axis_arb_mux
// Purpose  : N-input AXI-stream packet mux with per-packet arbitration
//            and a 2-entry registered skid buffer on the output.
// Revision : 1.0
// ============================================================================
module axis_arb_mux #(
    parameter  int NUM_IN   = 4,
    parameter  int DW       = 512,
    parameter  int ARB_MODE = 1,
    localparam int GW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_IN*DW-1:0] in_tdata,
    input  logic [NUM_IN-1:0]    in_tlast,
    input  logic [NUM_IN-1:0]    in_tvalid,
    output logic [NUM_IN-1:0]    in_tready,
    output logic [DW-1:0]        axis_out_tdata,
    output logic                 axis_out_tlast,
    output logic                 axis_out_tvalid,
    input  logic                 axis_out_tready,
    output logic [GW-1:0]        grant_idx,
    output logic                 busy
);

    localparam logic [0:0]    c_IDLE     = 1'b0;
    localparam logic [0:0]    c_LOCKED   = 1'b1;
    localparam logic [GW-1:0] c_LAST_IDX = GW'(NUM_IN - 1);

    logic [0:0]    r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_ptr;

    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_out_valid;
    logic [DW-1:0] r_skid_data;
    logic          r_skid_last;
    logic          r_skid_valid;

    logic [GW-1:0] w_win;
    logic          w_found;
    int            w_idx;
    logic [DW-1:0] w_sel_data;
    logic          w_sel_last;
    logic          w_accept;
    logic          w_pop;

    // Search order starts at 0 (fixed priority) or at the pointer (round robin).
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ARB_MODE == 0) begin
                w_idx = k;
            end else begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NUM_IN) begin
                    w_idx = w_idx - NUM_IN;
                end
            end
            if (!w_found && in_tvalid[w_idx]) begin
                w_win   = w_idx[GW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_data = in_tdata[int'(r_grant)*DW +: DW];
    assign w_sel_last = in_tlast[r_grant];
    // Skid valid implies output valid, so "skid empty" means an entry is free.
    assign w_accept   = (r_state == c_LOCKED) && !r_skid_valid && in_tvalid[r_grant];
    assign w_pop      = r_out_valid && axis_out_tready;

    always_comb begin
        in_tready = '0;
        if ((r_state == c_LOCKED) && !r_skid_valid) begin
            in_tready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_state <= c_LOCKED;
                    end
                end
                c_LOCKED: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= c_IDLE;
                        r_ptr   <= (r_grant == c_LAST_IDX) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Output register is the head entry; the skid register holds the second beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_last   <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= w_sel_data;
                    r_out_last <= w_sel_last;
                end
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                r_skid_data  <= w_sel_data;
                r_skid_last  <= w_sel_last;
                r_skid_valid <= 1'b1;
            end else begin
                r_out_data  <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign axis_out_tdata  = r_out_data;
    assign axis_out_tlast  = r_out_last;
    assign axis_out_tvalid = r_out_valid;
    assign grant_idx       = r_grant;
    assign busy            = (r_state == c_LOCKED);

endmodule
`default_nettype wire

// File: doc/axis_arb_mux.md
Name: axis_arb_mux

Overview:
- Parametrised N-input AXI-stream packet multiplexer. It is the successor to the two-input "only one source active" mux.
- Arbitrates between any number of simultaneously active sources. Once a source wins, it holds the output for the whole packet, until tlast.
- Output is registered through a 2-entry skid buffer, so there is no combinational path from output to input.
- Sits ahead of the NIC transmit path, merging the packet generators and the buffer readers.

Parameters:
- NUM_IN, 4: number of input streams, legal range 2..16.
- DW, 512: tdata width in bits.
- ARB_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round robin.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_tdata  in  NUM_IN*DW  input data; input i occupies bits [i*DW +: DW].
- in_tlast  in  NUM_IN  per-input end of packet.
- in_tvalid  in  NUM_IN  per-input valid.
- in_tready  out  NUM_IN  per-input ready; at most one bit set at any time.
- axis_out_tdata  out  DW  output data, registered.
- axis_out_tlast  out  1  output end of packet, registered.
- axis_out_tvalid  out  1  output valid, registered.
- axis_out_tready  in  1  downstream ready.
- grant_idx  out  GW  index of the current or last granted input; GW = max(1, clog2(NUM_IN)).
- busy  out  1  high while in the LOCKED state.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - axis_out_tvalid=0, axis_out_tdata=0, axis_out_tlast=0.
  - in_tready=0, grant_idx=0, busy=0.
  - Round-robin pointer=0, skid buffer empty, state=IDLE.
- State machine, two states:
  - IDLE: all in_tready=0. If any in_tvalid is set, the winner is registered into grant_idx and the state goes to LOCKED on the next edge. If no in_tvalid is set, the state stays IDLE.
  - LOCKED: in_tready[grant_idx] = skid buffer has at least one free entry. A beat is accepted when in_tvalid & in_tready. An accepted beat with tlast=1 returns the state to IDLE on that edge.
- Arbitration:
  - ARB_MODE=0: lowest set index of in_tvalid wins.
  - ARB_MODE=1: first set index at or above the pointer, wrapping modulo NUM_IN.
  - The pointer updates to (grant_idx+1) mod NUM_IN only when a tlast beat is accepted. Wrap example: NUM_IN=4, grant 3 -> pointer 0.
  - in_tvalid is sampled only in IDLE. Valids arriving on non-granted inputs during LOCKED are ignored until the next arbitration.
- Latency and throughput:
  - First beat of a packet appears on axis_out_tvalid 2 cycles after its in_tvalid rises with the mux IDLE and empty: 1 cycle arbitrate, 1 cycle register.
  - 1 beat per cycle sustained inside a packet while axis_out_tready=1.
  - Exactly 1 idle input cycle between consecutive packets (the IDLE cycle).
- Skid buffer:
  - 2 entries.
  - in_tready is derived from registered occupancy only: ready while occupancy < 2, i.e. an entry is free.
  - With occupancy=1, a simultaneous push and pop leaves occupancy at 1.
  - Data order is preserved. When occupancy=0, axis_out_tvalid=0.
  - The output holds tdata and tlast stable while tvalid=1 and tready=0 (AXI rule).
- Granted input drops tvalid mid-packet: stay LOCKED, no beats accepted, no timeout.
- Single-beat packet (tlast on the first beat): LOCKED for one accepted beat only.
- Reset mid-packet: the packet is truncated. Buffered beats are discarded, and downstream sees no tlast. Recovery is the system's responsibility.
- No beat is ever duplicated or dropped outside reset.

Test Plan:
1. NUM_IN=4, ARB_MODE=1. Inputs 0..3 each hold a 3-beat packet (tdata = index*16+beat), all valid at cycle 0, axis_out_tready=1 -> output packet order 0,1,2,3; 12 beats, tlast on beats 3,6,9,12; first beat at cycle 2; exactly 1 bubble between packets.
2. ARB_MODE=0, same stimulus, with input 0 re-presenting a new packet immediately after each tlast -> input 0 wins every arbitration; inputs 1..3 are starved while input 0 is active.
3. Backpressure: 8-beat packet on input 2, axis_out_tready toggling 1,0,0,1 repeating -> all 8 beats are in order with no loss; data stays stable while stalled; in_tready[2] drops only once the skid buffer holds 2 entries.
4. Wrap: NUM_IN=4, RR, grant input 3, then inputs 0 and 2 become valid -> next grant is 0, and grant_idx is 3 then 0.
5. Granted input 1 drops tvalid for 5 cycles mid-packet while input 0 is valid -> busy stays 1, in_tready[0] stays 0, and input 1's packet completes before input 0 is granted.
6. Reset asserted on beat 2 of a 4-beat packet -> all outputs return to their reset values in the same cycle; after release, a fresh packet on input 0 emerges with its first beat 2 cycles after tvalid.
